control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have parameter WORDSIZE, default 64: datapath word width.
REQ-003 The block SHALL have parameter RESET_PC, default 0: PC value after reset.
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  WORDSIZE  fetch address (current PC)
- imem_data  in  32  instruction word
- imem_valid  in  1  imem_data valid; sampled only in FETCH
- alu_result  in  WORDSIZE  datapath ALU result; BEQ taken when zero
- rf_addr_a, rf_addr_b, rf_write_addr  out  5 each  register-file addresses
- rf_write_en  out  1  register write strobe
- immediate  out  WORDSIZE  sign-extended immediate
- mux_0_sel, mux_1_sel, mux_2_sel  out  1 each  datapath mux selects; 0 selects input_a
- alu_operation  out  3  ALU opcode
- dm_write_en  out  1  data-memory write strobe
- halted  out  1  sticky; ECALL or illegal instruction seen
- illegal_instr  out  1  sticky; unsupported encoding seen

Function
REQ-005 The block SHALL use FSM states FETCH, DECODE, EXECUTE, MEM, WB, HALT.
REQ-006 In FETCH, imem_req SHALL be 1 with imem_addr=PC; on imem_valid=1 the block SHALL latch imem_data into IR and go to DECODE; otherwise it SHALL stay in FETCH indefinitely.
REQ-007 In DECODE, rf_addr_a=IR[19:15], rf_addr_b=IR[24:20], rf_write_addr=IR[11:7] and immediate SHALL be registered and held until the next DECODE.
REQ-008 The block SHALL support ADD, SUB, AND, OR (opcode 0110011), ADDI (0010011), LD (0000011, funct3 011), SD (0100011, funct3 011), BEQ (1100011, funct3 000), ECALL (0x00000073).
REQ-009 Immediates SHALL be sign-extended to WORDSIZE: I-type IR[31:20]; S-type {IR[31:25],IR[11:7]}; B-type {IR[31],IR[7],IR[30:25],IR[11:8],0}.
REQ-010 From EXECUTE until the next DECODE: mux_0_sel=0; mux_1_sel=1 for R-type/BEQ, else 0; alu_operation=SUB for SUB/BEQ, AND/OR for those, else ADD; mux_2_sel=1 for LD, else 0.
REQ-011 Transitions SHALL be: R-type/ADDI EXECUTE->WB; LD EXECUTE->MEM->WB; SD EXECUTE->MEM->FETCH; BEQ EXECUTE->FETCH; WB->FETCH.
REQ-012 rf_write_en SHALL be 1 for exactly the single WB cycle; dm_write_en SHALL be 1 for exactly the single SD MEM cycle; both 0 elsewhere.
REQ-013 PC SHALL update once per instruction on leaving the final state: BEQ with alu_result==0 -> PC+immediate, else PC+4, wrapping modulo 2^WORDSIZE.
REQ-014 Cycle counts from imem_valid acceptance to next FETCH entry SHALL be: BEQ 2, R/ADDI 3, SD 3, LD 4.
REQ-015 ECALL SHALL go DECODE->HALT; unsupported opcode/funct SHALL set illegal_instr and go DECODE->HALT; no write strobe SHALL fire for either.
REQ-016 HALT SHALL be absorbing: imem_req=0, strobes 0, halted=1, PC frozen until rst.
REQ-017 imem_valid outside FETCH SHALL be ignored.

Reset
REQ-018 When rst=1 at a clock edge, the block SHALL enter FETCH with PC=RESET_PC, IR=0, all addresses/immediate/selects/alu_operation=0, rf_write_en=dm_write_en=halted=illegal_instr=0, from any state including mid-instruction.
REQ-019 A strobe due in the reset cycle SHALL NOT be asserted; imem_req SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-020 A shared package cpu_ctrl_pkg SHALL hold opcode/funct3/funct7 constants, ALU encodings (ADD=000, SUB=001, AND=010, OR=011) and the FSM state enum.
REQ-021 Immediate extraction SHALL be a combinational sub-module imm_gen instantiated once.

Verification
REQ-022 ADD 0x002081B3 at PC 0 -> addrs 1/2/3, mux 0/1/0, alu ADD, rf_write_en one cycle, PC=4.
REQ-023 ADDI 0xFFF00293 -> immediate=0xFFFFFFFFFFFFFFFF, mux_1_sel=0, rf_write_addr=5.
REQ-024 LD 0x0080B303 -> immediate=8, mux_2_sel=1, rf_write_en only in 4th cycle after accept; SD 0x0020B823 -> immediate=16, dm_write_en one cycle, rf_write_en never.
REQ-025 BEQ 0xFE208CE3 at PC 0x10: alu_result=0 -> PC=0x08; alu_result=5 -> PC=0x14.
REQ-026 ECALL 0x00000073 -> halted=1, imem_req stays 0; opcode 0x7F -> illegal_instr=1; rst asserted in EXECUTE -> FETCH, PC=0, no strobe.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared encodings, FSM states and instruction classifier for the control unit
package cpu_ctrl_pkg;
   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_AND     = 3'b111;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_DWORD   = 3'b011;
   localparam logic [2:0] F3_BEQ     = 3'b000;
   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_SUB     = 7'b0100000;
   localparam logic [31:0] ECALL_WORD = 32'h0000_0073;
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;

   typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, HALT} state_t;

   typedef enum logic [3:0] {
      I_ADD, I_SUB, I_AND, I_OR, I_ADDI, I_LD, I_SD, I_BEQ, I_ECALL, I_ILLEGAL
   } instr_t;

   function automatic instr_t classify(input logic [31:0] ir);
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      logic       r_base;
      opc    = ir[6:0];
      f3     = ir[14:12];
      f7     = ir[31:25];
      r_base = opc == OPC_RTYPE && f7 == F7_BASE;
      return ir == ECALL_WORD                                   ? I_ECALL :
             r_base && f3 == F3_ADD_SUB                         ? I_ADD   :
             opc == OPC_RTYPE && f7 == F7_SUB && f3 == F3_ADD_SUB ? I_SUB :
             r_base && f3 == F3_AND                             ? I_AND   :
             r_base && f3 == F3_OR                              ? I_OR    :
             opc == OPC_ITYPE && f3 == F3_ADD_SUB               ? I_ADDI  :
             opc == OPC_LOAD && f3 == F3_DWORD                  ? I_LD    :
             opc == OPC_STORE && f3 == F3_DWORD                 ? I_SD    :
             opc == OPC_BRANCH && f3 == F3_BEQ                  ? I_BEQ   :
                                                                  I_ILLEGAL;
   endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: sign-extended I/S/B immediate extraction from a raw instruction word
module imm_gen
   import cpu_ctrl_pkg::*;
#(
   parameter int WORDSIZE = 64
) (
   input  logic [31:0]         instr,
   output logic [WORDSIZE-1:0] imm
);
   logic [11:0] imm_i;
   logic [11:0] imm_s;
   logic [12:0] imm_b;
   logic        unused_fields;

   assign imm_i         = instr[31:20];
   assign imm_s         = {instr[31:25], instr[11:7]};
   assign imm_b         = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign unused_fields = ^instr[19:12];

   // Stores and branches use their split fields; every other encoding takes the I-type field
   always_comb
      imm = instr[6:0] == OPC_STORE  ? {{(WORDSIZE-12){imm_s[11]}}, imm_s} :
            instr[6:0] == OPC_BRANCH ? {{(WORDSIZE-13){imm_b[12]}}, imm_b} :
                                       {{(WORDSIZE-12){imm_i[11]}}, imm_i};
endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute sequencer for a small RV64 subset
module control_unit
   import cpu_ctrl_pkg::*;
#(
   parameter int                  WORDSIZE = 64,
   parameter logic [WORDSIZE-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   output logic                imem_req,
   output logic [WORDSIZE-1:0] imem_addr,
   input  logic [31:0]         imem_data,
   input  logic                imem_valid,
   input  logic [WORDSIZE-1:0] alu_result,
   output logic [4:0]          rf_addr_a,
   output logic [4:0]          rf_addr_b,
   output logic [4:0]          rf_write_addr,
   output logic                rf_write_en,
   output logic [WORDSIZE-1:0] immediate,
   output logic                mux_0_sel,
   output logic                mux_1_sel,
   output logic                mux_2_sel,
   output logic [2:0]          alu_operation,
   output logic                dm_write_en,
   output logic                halted,
   output logic                illegal_instr
);
   state_t              state;
   state_t              next_state;
   instr_t              cls;
   logic [31:0]         ir;
   logic [WORDSIZE-1:0] pc;
   logic [WORDSIZE-1:0] imm_next;
   logic                accept;
   logic                retire;
   logic                taken;

   assign cls       = classify(ir);
   assign accept    = state == FETCH && imem_valid;
   assign retire    = state == WB || (state == EXECUTE && cls == I_BEQ) || (state == MEM && cls == I_SD);
   assign taken     = cls == I_BEQ && alu_result == '0;
   assign imem_addr = pc;
   assign mux_0_sel = 1'b0;

   imm_gen #(.WORDSIZE(WORDSIZE)) u_imm_gen (
      .instr(imem_data),
      .imm  (imm_next)
   );

   // Next state and per-state strobes; strobes are suppressed while reset is applied
   always_comb begin
      next_state  = state;
      imem_req    = state == FETCH;
      halted      = state == HALT;
      rf_write_en = state == WB && !rst;
      dm_write_en = state == MEM && cls == I_SD && !rst;
      case (state)
         FETCH:   next_state = imem_valid ? DECODE : FETCH;
         DECODE:  next_state = cls inside {I_ECALL, I_ILLEGAL} ? HALT : EXECUTE;
         EXECUTE: next_state = cls inside {I_LD, I_SD} ? MEM : cls == I_BEQ ? FETCH : WB;
         MEM:     next_state = cls == I_LD ? WB : FETCH;
         WB:      next_state = FETCH;
         HALT:    next_state = HALT;
         default: next_state = FETCH;
      endcase
   end

   // State, instruction register, decoded fields and PC; fields appear at the start of DECODE
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= FETCH;
         pc            <= RESET_PC;
         ir            <= '0;
         rf_addr_a     <= '0;
         rf_addr_b     <= '0;
         rf_write_addr <= '0;
         immediate     <= '0;
         mux_1_sel     <= 1'b0;
         mux_2_sel     <= 1'b0;
         alu_operation <= ALU_ADD;
         illegal_instr <= 1'b0;
      end else begin
         state <= next_state;
         if (accept) begin
            ir            <= imem_data;
            rf_addr_a     <= imem_data[19:15];
            rf_addr_b     <= imem_data[24:20];
            rf_write_addr <= imem_data[11:7];
            immediate     <= imm_next;
         end
         if (state == DECODE && next_state == EXECUTE) begin
            mux_1_sel     <= cls inside {I_ADD, I_SUB, I_AND, I_OR, I_BEQ};
            mux_2_sel     <= cls == I_LD;
            alu_operation <= cls inside {I_SUB, I_BEQ} ? ALU_SUB :
                             cls == I_AND ? ALU_AND : cls == I_OR ? ALU_OR : ALU_ADD;
         end
         if (state == DECODE && cls == I_ILLEGAL)
            illegal_instr <= 1'b1;
         if (retire)
            pc <= pc + (taken ? immediate : WORDSIZE'(4));
      end
   end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized scoreboard bench for control_unit
module tb_control_unit;
   localparam int W = 64;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         imem_req;
   logic [W-1:0] imem_addr;
   logic [31:0]  imem_data = '0;
   logic         imem_valid = 1'b0;
   logic [W-1:0] alu_result = '0;
   logic [4:0]   rf_addr_a, rf_addr_b, rf_write_addr;
   logic         rf_write_en;
   logic [W-1:0] immediate;
   logic         mux_0_sel, mux_1_sel, mux_2_sel;
   logic [2:0]   alu_operation;
   logic         dm_write_en, halted, illegal_instr;

   always #5 clk = ~clk;

   control_unit #(.WORDSIZE(W), .RESET_PC('0)) dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_data(imem_data), .imem_valid(imem_valid), .alu_result(alu_result),
      .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_write_addr(rf_write_addr),
      .rf_write_en(rf_write_en), .immediate(immediate), .mux_0_sel(mux_0_sel),
      .mux_1_sel(mux_1_sel), .mux_2_sel(mux_2_sel), .alu_operation(alu_operation),
      .dm_write_en(dm_write_en), .halted(halted), .illegal_instr(illegal_instr)
   );

   typedef struct {
      logic [31:0] w;
      int          cyc, wb_at, dm_at;
      logic [4:0]  ra, rb, rd;
      logic [63:0] imm, next_pc;
      bit          chk_imm, m1, m2, halt, ill;
      logic [2:0]  alu;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          failures = 0;
   logic [63:0] model_pc = '0;
   bit          direct = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Kinds: 0 ADD 1 SUB 2 AND 3 OR 4 ADDI 5 LD 6 SD 7 BEQ 8 ECALL 9 opcode 0x7F 10 bad funct7
   task automatic make(input int k, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [12:0] imm, input logic [63:0] alu, output exp_t e);
      logic [31:0] w;
      logic [6:0]  f7;
      logic [2:0]  f3;
      f7 = k == 1 ? 7'h20 : k == 10 ? 7'h01 : 7'h00;
      f3 = k == 2 ? 3'b111 : k == 3 ? 3'b110 : 3'b000;
      case (k)
         0, 1, 2, 3, 10: w = {f7, rs2, rs1, f3, rd, 7'h33};
         4:       w = {imm[11:0], rs1, 3'b000, rd, 7'h13};
         5:       w = {imm[11:0], rs1, 3'b011, rd, 7'h03};
         6:       w = {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'h23};
         7:       w = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
         8:       w = 32'h0000_0073;
         default: w = 32'h0000_007F;
      endcase
      e.w       = w;
      e.ra      = w[19:15];
      e.rb      = w[24:20];
      e.rd      = w[11:7];
      e.imm     = k == 7 ? longint'($signed(imm)) : longint'($signed(imm[11:0]));
      e.chk_imm = k >= 4 && k <= 7;
      e.m1      = k <= 3 || k == 7;
      e.m2      = k == 5;
      e.alu     = (k == 1 || k == 7) ? 3'd1 : k == 2 ? 3'd2 : k == 3 ? 3'd3 : 3'd0;
      e.halt    = k >= 8;
      e.ill     = k >= 9;
      e.cyc     = e.halt ? 2 : k == 7 ? 3 : k == 5 ? 5 : 4;
      e.wb_at   = k <= 4 ? 3 : k == 5 ? 4 : 0;
      e.dm_at   = k == 6 ? 3 : 0;
      e.next_pc = e.halt ? model_pc : (k == 7 && alu == '0) ? model_pc + e.imm : model_pc + 64'd4;
      model_pc  = e.next_pc;
   endtask

   task automatic issue(input exp_t e, input logic [63:0] alu, input bit push);
      int n = 0;
      while (!imem_req && n < 40) begin
         imem_valid = 1'($urandom_range(0, 1));
         imem_data  = $urandom;
         @(negedge clk);
         n++;
      end
      imem_valid = 1'b0;
      if (!imem_req) begin
         $display("FAIL fetch_wait: imem_req 0 after %0d cycles expected 1", n);
         $fatal(1, "fetch request never returned");
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (push) q.push_back(e);
      imem_data  = e.w;
      imem_valid = 1'b1;
      alu_result = alu;
      @(negedge clk);
      imem_valid = 1'b0;
      imem_data  = $urandom;
   endtask

   task automatic halt_check();
      bit bad = 1'b0;
      @(negedge clk);
      repeat (6) begin
         imem_valid = 1'b1;
         imem_data  = $urandom;
         @(negedge clk);
         #1;
         if (imem_req || !halted || rf_write_en || dm_write_en || imem_addr !== model_pc) bad = 1'b1;
      end
      imem_valid = 1'b0;
      chk("halt_absorbing", 64'(bad), 64'd0);
   endtask

   task automatic do_reset(input int n);
      rst        = 1'b1;
      imem_valid = 1'b0;
      repeat (n) @(negedge clk);
      rst      = 1'b0;
      model_pc = '0;
      #1;
      chk("rst_imem_req", 64'(imem_req), 64'd1);
      chk("rst_pc", imem_addr, 64'd0);
      chk("rst_addrs", 64'({rf_addr_a, rf_addr_b, rf_write_addr}), 64'd0);
      chk("rst_imm", immediate, 64'd0);
      chk("rst_sel", 64'({mux_0_sel, mux_1_sel, mux_2_sel, alu_operation}), 64'd0);
      chk("rst_strobes", 64'({rf_write_en, dm_write_en}), 64'd0);
      chk("rst_flags", 64'({halted, illegal_instr}), 64'd0);
   endtask

   // Monitor: pops the expected record on each accepted fetch and follows the instruction to its end
   initial begin
      exp_t e;
      int   n, wbn, wbc, dmn, dmc;
      bit   again = 1'b0;
      forever begin
         if (!again) begin
            @(negedge clk);
            #1;
         end
         again = 1'b0;
         if (imem_req && imem_valid && !direct && !rst) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL scoreboard_empty: got 0 entries expected 1");
            end else begin
               e = q.pop_front();
               n = 0; wbn = 0; wbc = 0; dmn = 0; dmc = 0;
               do begin
                  @(negedge clk);
                  #1;
                  n++;
                  if (rf_write_en) begin wbc++; wbn = n; end
                  if (dm_write_en) begin dmc++; dmn = n; end
               end while (!imem_req && !halted && n < 12);
               chk($sformatf("cycles[%h]", e.w), 64'(n), 64'(e.cyc));
               chk($sformatf("rf_we_count[%h]", e.w), 64'(wbc), 64'(e.wb_at != 0));
               chk($sformatf("rf_we_cycle[%h]", e.w), 64'(wbn), 64'(e.wb_at));
               chk($sformatf("dm_we_count[%h]", e.w), 64'(dmc), 64'(e.dm_at != 0));
               chk($sformatf("dm_we_cycle[%h]", e.w), 64'(dmn), 64'(e.dm_at));
               chk($sformatf("pc[%h]", e.w), imem_addr, e.next_pc);
               chk($sformatf("halted[%h]", e.w), 64'(halted), 64'(e.halt));
               chk($sformatf("illegal[%h]", e.w), 64'(illegal_instr), 64'(e.ill));
               if (e.halt)
                  chk($sformatf("halt_req[%h]", e.w), 64'(imem_req), 64'd0);
               else begin
                  chk($sformatf("addrs[%h]", e.w), 64'({rf_addr_a, rf_addr_b, rf_write_addr}), 64'({e.ra, e.rb, e.rd}));
                  chk($sformatf("mux[%h]", e.w), 64'({mux_0_sel, mux_1_sel, mux_2_sel}), 64'({1'b0, e.m1, e.m2}));
                  chk($sformatf("alu_op[%h]", e.w), 64'(alu_operation), 64'(e.alu));
               end
               if (e.chk_imm)
                  chk($sformatf("imm[%h]", e.w), immediate, e.imm);
               again = 1'b1;
            end
         end
      end
   end

   // Stimulus: directed encodings first, reset corner cases, then a random instruction stream
   initial begin
      exp_t        e;
      logic [63:0] alu;
      logic [12:0] imm;
      int          k;
      @(negedge clk);
      do_reset(2);
      make(0, 5'd3, 5'd1, 5'd2, 13'd0, 64'd0, e);       issue(e, 64'd0, 1'b1);
      make(4, 5'd5, 5'd0, 5'd0, 13'h0FFF, 64'd0, e);    issue(e, 64'd0, 1'b1);
      make(5, 5'd6, 5'd1, 5'd0, 13'd8, 64'd0, e);       issue(e, 64'd0, 1'b1);
      make(6, 5'd0, 5'd1, 5'd2, 13'd16, 64'd0, e);      issue(e, 64'd0, 1'b1);
      make(7, 5'd0, 5'd1, 5'd2, 13'h1FF8, 64'd0, e);    issue(e, 64'd0, 1'b1);
      make(0, 5'd3, 5'd1, 5'd2, 13'd0, 64'd5, e);       issue(e, 64'd5, 1'b1);
      make(1, 5'd4, 5'd7, 5'd9, 13'd0, 64'd5, e);       issue(e, 64'd5, 1'b1);
      make(7, 5'd0, 5'd1, 5'd2, 13'h1FF8, 64'd5, e);    issue(e, 64'd5, 1'b1);
      make(8, 5'd0, 5'd0, 5'd0, 13'd0, 64'd0, e);       issue(e, 64'd0, 1'b1);
      halt_check();
      do_reset(1);
      make(9, 5'd0, 5'd0, 5'd0, 13'd0, 64'd0, e);       issue(e, 64'd0, 1'b1);
      halt_check();
      do_reset(2);
      direct = 1'b1;
      make(6, 5'd0, 5'd1, 5'd2, 13'd16, 64'd0, e);      issue(e, 64'd0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_in_exec_strobes", 64'({rf_write_en, dm_write_en}), 64'd0);
      do_reset(1);
      make(0, 5'd3, 5'd1, 5'd2, 13'd0, 64'd0, e);       issue(e, 64'd0, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_in_wb_strobe", 64'(rf_write_en), 64'd0);
      do_reset(1);
      direct = 1'b0;
      for (int i = 0; i < 200; i++) begin
         k   = $urandom_range(0, 19) == 0 ? 10 : $urandom_range(0, 7);
         imm = 13'($urandom);
         if (k == 7) imm[0] = 1'b0;
         alu = $urandom_range(0, 1) == 1 ? 64'd0 : ({$urandom, $urandom} | 64'd1);
         make(k, 5'($urandom), 5'($urandom), 5'($urandom), imm, alu, e);
         issue(e, alu, 1'b1);
         if (e.halt) begin
            halt_check();
            do_reset(1);
         end
      end
      repeat (8) @(negedge clk);
      chk("scoreboard_drained", 64'(q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
